// File: rtl/xadac_axi_wmem.sv
// Single-beat AXI write subordinate: AW/W beats are queued, paired in arrival order
// and committed into a byte-strobed word memory with one outstanding B response.

module xadac_axi_wmem_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int unsigned PtrWidth = $clog2(Depth);
    localparam int unsigned CntWidth = PtrWidth + 1;

    logic [Width-1:0]    mem_q [Depth];
    logic [PtrWidth-1:0] wptr_q, wptr_d;
    logic [PtrWidth-1:0] rptr_q, rptr_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;

    // Depth is a power of two, so the pointers wrap naturally.
    always_comb begin
        wptr_d = wptr_q + PtrWidth'(push_i);
        rptr_d = rptr_q + PtrWidth'(pop_i);
        cnt_d  = cnt_q + CntWidth'(push_i) - CntWidth'(pop_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rptr_q];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CntWidth'(Depth));
endmodule

module xadac_axi_wmem #(
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned Depth     = 256,
    parameter int unsigned FifoDepth = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IdWidth-1:0]       axi_aw_id,
    input  logic [AddrWidth-1:0]     axi_aw_addr,
    input  logic                     axi_aw_valid,
    output logic                     axi_aw_ready,
    input  logic [DataWidth-1:0]     axi_w_data,
    input  logic [DataWidth/8-1:0]   axi_w_strb,
    input  logic                     axi_w_valid,
    output logic                     axi_w_ready,
    output logic [IdWidth-1:0]       axi_b_id,
    output logic                     axi_b_valid,
    input  logic                     axi_b_ready,
    input  logic                     rd_en,
    input  logic [$clog2(Depth)-1:0] rd_addr,
    output logic [DataWidth-1:0]     rd_data
);
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned OffWidth  = $clog2(StrbWidth);
    localparam int unsigned IdxWidth  = $clog2(Depth);
    localparam int unsigned AwWidth   = IdWidth + IdxWidth;
    localparam int unsigned WWidth    = DataWidth + StrbWidth;

    logic                 aw_push, aw_empty, aw_full;
    logic                 w_push, w_empty, w_full;
    logic [AwWidth-1:0]   aw_head;
    logic [WWidth-1:0]    w_head;
    logic [IdWidth-1:0]   head_id;
    logic [IdxWidth-1:0]  head_idx, aw_idx;
    logic [DataWidth-1:0] head_data;
    logic [StrbWidth-1:0] head_strb;
    logic                 commit;

    logic                 b_valid_q, b_valid_d;
    logic [IdWidth-1:0]   b_id_q, b_id_d;
    logic [DataWidth-1:0] rd_data_q;
    logic [DataWidth-1:0] mem_q [Depth];

    // Only the word index is kept; byte-offset and wrapped upper address bits are dropped.
    assign aw_idx = axi_aw_addr[OffWidth +: IdxWidth];
    logic unused_addr_bits;
    assign unused_addr_bits = ^{axi_aw_addr[AddrWidth-1:OffWidth+IdxWidth],
                                axi_aw_addr[OffWidth-1:0]};

    assign axi_aw_ready = !rst && !aw_full;
    assign axi_w_ready  = !rst && !w_full;
    assign aw_push      = axi_aw_valid && axi_aw_ready;
    assign w_push       = axi_w_valid && axi_w_ready;

    xadac_axi_wmem_fifo #(.Width(AwWidth), .Depth(FifoDepth)) u_aw_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (aw_push),
        .data_i  ({axi_aw_id, aw_idx}),
        .pop_i   (commit),
        .data_o  (aw_head),
        .empty_o (aw_empty),
        .full_o  (aw_full)
    );

    xadac_axi_wmem_fifo #(.Width(WWidth), .Depth(FifoDepth)) u_w_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .data_i  ({axi_w_data, axi_w_strb}),
        .pop_i   (commit),
        .data_o  (w_head),
        .empty_o (w_empty),
        .full_o  (w_full)
    );

    assign {head_id, head_idx}    = aw_head;
    assign {head_data, head_strb} = w_head;

    // The single B register is the only completion slot, so a commit needs it free
    // or being drained this cycle.
    assign commit = !rst && !aw_empty && !w_empty && (!b_valid_q || axi_b_ready);

    always_comb begin
        b_valid_d = b_valid_q;
        b_id_d    = b_id_q;
        if (commit) begin
            b_valid_d = 1'b1;
            b_id_d    = head_id;
        end else if (axi_b_ready) begin
            b_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_valid_q <= 1'b0;
            b_id_q    <= '0;
            rd_data_q <= '0;
        end else begin
            b_valid_q <= b_valid_d;
            b_id_q    <= b_id_d;
            if (rd_en) begin
                rd_data_q <= mem_q[rd_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < StrbWidth; b++) begin
                if (head_strb[b]) begin
                    mem_q[head_idx][8*b +: 8] <= head_data[8*b +: 8];
                end
            end
        end
    end

    assign axi_b_valid = b_valid_q;
    assign axi_b_id    = b_id_q;
    assign rd_data     = rd_data_q;
endmodule

// File: tb/tb_xadac_axi_wmem.sv
// Randomized and directed bench for xadac_axi_wmem against a transaction-level
// model: in-order AW/W pairing, in-order B ids and a byte-wise memory image.

module tb_xadac_axi_wmem;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  axi_aw_id;
    logic [31:0] axi_aw_addr;
    logic        axi_aw_valid;
    logic        axi_aw_ready;
    logic [63:0] axi_w_data;
    logic [7:0]  axi_w_strb;
    logic        axi_w_valid;
    logic        axi_w_ready;
    logic [3:0]  axi_b_id;
    logic        axi_b_valid;
    logic        axi_b_ready;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [63:0] rd_data;

    always #5 clk = ~clk;

    xadac_axi_wmem dut (
        .clk          (clk),
        .rst          (rst),
        .axi_aw_id    (axi_aw_id),
        .axi_aw_addr  (axi_aw_addr),
        .axi_aw_valid (axi_aw_valid),
        .axi_aw_ready (axi_aw_ready),
        .axi_w_data   (axi_w_data),
        .axi_w_strb   (axi_w_strb),
        .axi_w_valid  (axi_w_valid),
        .axi_w_ready  (axi_w_ready),
        .axi_b_id     (axi_b_id),
        .axi_b_valid  (axi_b_valid),
        .axi_b_ready  (axi_b_ready),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: queued beats, paired writes awaiting B, memory image with
    // per-byte knowledge (bytes touched by writes dropped by reset become unknown).
    typedef struct {
        logic [3:0]  id;
        int          idx;
        logic [63:0] data;
        logic [7:0]  strb;
    } txn_t;

    logic [3:0]  awid_q [$];
    int          awidx_q [$];
    logic [63:0] wd_q [$];
    logic [7:0]  ws_q [$];
    txn_t        pend [$];
    logic [63:0] mem_m [256];
    logic [7:0]  kb [256];
    int          n_aw_hs = 0;
    int          n_w_hs = 0;
    logic        prev_stall = 1'b0;
    logic [3:0]  prev_id = '0;
    txn_t        mt;

    function automatic logic [63:0] bmask(input logic [7:0] k);
        logic [63:0] m;
        m = '0;
        for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{k[b]}};
        return m;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) begin
            kb[i] = '0;
            mem_m[i] = '0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            foreach (pend[k]) kb[pend[k].idx] = kb[pend[k].idx] & ~pend[k].strb;
            pend.delete();
            awid_q.delete();
            awidx_q.delete();
            wd_q.delete();
            ws_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("b_hold_valid", axi_b_valid, 1);
                chk("b_hold_id", axi_b_id, prev_id);
            end
            if (axi_b_valid && axi_b_ready) begin
                if (pend.size() == 0) begin
                    chk("b_unexpected", axi_b_valid, 0);
                end else begin
                    mt = pend.pop_front();
                    chk("b_id", axi_b_id, mt.id);
                    for (int b = 0; b < 8; b++) begin
                        if (mt.strb[b]) begin
                            mem_m[mt.idx][8*b +: 8] = mt.data[8*b +: 8];
                            kb[mt.idx][b] = 1'b1;
                        end
                    end
                end
            end
            prev_stall = axi_b_valid && !axi_b_ready;
            prev_id = axi_b_id;
            if (axi_aw_valid && axi_aw_ready) begin
                awid_q.push_back(axi_aw_id);
                awidx_q.push_back(int'(axi_aw_addr / 8) % 256);
                n_aw_hs++;
            end
            if (axi_w_valid && axi_w_ready) begin
                wd_q.push_back(axi_w_data);
                ws_q.push_back(axi_w_strb);
                n_w_hs++;
            end
            while (awid_q.size() > 0 && wd_q.size() > 0) begin
                mt.id = awid_q.pop_front();
                mt.idx = awidx_q.pop_front();
                mt.data = wd_q.pop_front();
                mt.strb = ws_q.pop_front();
                pend.push_back(mt);
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr);
        int n = 0;
        axi_aw_id = id;
        axi_aw_addr = addr;
        axi_aw_valid = 1'b1;
        @(negedge clk);
        while (!axi_aw_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) chk("aw_timeout", axi_aw_ready, 1);
        @(posedge clk);
        #1;
        axi_aw_valid = 1'b0;
    endtask

    task automatic w_send(input logic [63:0] data, input logic [7:0] strb);
        int n = 0;
        axi_w_data = data;
        axi_w_strb = strb;
        axi_w_valid = 1'b1;
        @(negedge clk);
        while (!axi_w_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) chk("w_timeout", axi_w_ready, 1);
        @(posedge clk);
        #1;
        axi_w_valid = 1'b0;
    endtask

    task automatic write(input logic [3:0] id, input logic [31:0] addr,
                         input logic [63:0] data, input logic [7:0] strb);
        sync();
        fork
            aw_send(id, addr);
            w_send(data, strb);
        join
    endtask

    task automatic drain();
        int n = 0;
        axi_b_ready = 1'b1;
        while ((pend.size() != 0 || awid_q.size() != 0 || wd_q.size() != 0 || axi_b_valid)
               && n < 300) begin
            sync();
            n++;
        end
        if (n >= 300) chk("drain_timeout", pend.size(), 0);
        sync();
    endtask

    task automatic read_word(input int idx, output logic [63:0] val);
        sync();
        rd_en = 1'b1;
        rd_addr = idx[7:0];
        sync();
        rd_en = 1'b0;
        @(negedge clk);
        val = rd_data;
    endtask

    task automatic gap(input int k);
        repeat (k) sync();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    logic [63:0] v;
    logic [63:0] bp_data [4];
    int          base_aw, base_w;
    bit          aw_done, w_done;
    int unsigned n_rand = 80;

    initial begin
        rst = 1'b1;
        axi_aw_id = '0; axi_aw_addr = '0; axi_aw_valid = 1'b0;
        axi_w_data = '0; axi_w_strb = '0; axi_w_valid = 1'b0;
        axi_b_ready = 1'b1; rd_en = 1'b0; rd_addr = '0;

        // reset state
        @(negedge clk);
        chk("rst_aw_ready", axi_aw_ready, 0);
        chk("rst_w_ready", axi_w_ready, 0);
        chk("rst_b_valid", axi_b_valid, 0);
        chk("rst_b_id", axi_b_id, 0);
        chk("rst_rd_data", rd_data, 0);
        sync();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_aw_ready", axi_aw_ready, 1);
        chk("post_rst_w_ready", axi_w_ready, 1);

        // single write: latency N+2, then read back
        sync();
        axi_aw_id = 4'd3; axi_aw_addr = 32'h10; axi_aw_valid = 1'b1;
        axi_w_data = 64'h1122334455667788; axi_w_strb = 8'hFF; axi_w_valid = 1'b1;
        sync();
        axi_aw_valid = 1'b0; axi_w_valid = 1'b0;
        @(negedge clk);
        chk("lat_n1_b_valid", axi_b_valid, 0);
        @(negedge clk);
        chk("lat_n2_b_valid", axi_b_valid, 1);
        chk("lat_n2_b_id", axi_b_id, 3);
        @(negedge clk);
        chk("lat_n3_b_valid", axi_b_valid, 0);
        read_word(2, v);
        chk("single_rd", v, 64'h1122334455667788);
        @(negedge clk);
        chk("rd_hold", rd_data, 64'h1122334455667788);

        // partial strobe
        write(4'd1, 32'h0, 64'hAAAAAAAAAAAAAAAA, 8'hFF);
        write(4'd2, 32'h0, 64'h0, 8'h0F);
        drain();
        read_word(0, v);
        chk("partial_rd", v, 64'hAAAAAAAAAAAAAAAA & 64'hFFFFFFFF00000000);

        // all-zero strobe still gets a response and leaves word 2 intact
        write(4'd6, 32'h10, 64'hDEADBEEFDEADBEEF, 8'h00);
        drain();
        read_word(2, v);
        chk("zero_strb_rd", v, 64'h1122334455667788);

        // decoupled channels: W leads AW
        sync();
        w_send(64'h1, 8'hFF);
        w_send(64'h2, 8'hFF);
        @(negedge clk);
        chk("w_full_ready", axi_w_ready, 0);
        gap(5);
        @(negedge clk);
        chk("decoupled_no_b", axi_b_valid, 0);
        sync();
        aw_send(4'd1, 32'h0);
        aw_send(4'd2, 32'h8);
        drain();
        read_word(0, v);
        chk("decoupled_w0", v, 64'h1);
        read_word(1, v);
        chk("decoupled_w1", v, 64'h2);

        // backpressure
        for (int i = 0; i < 4; i++) bp_data[i] = {$urandom, $urandom};
        sync();
        axi_b_ready = 1'b0;
        base_aw = n_aw_hs;
        base_w = n_w_hs;
        fork
            begin
                for (int i = 0; i < 4; i++) aw_send(4'(4 + i), 32'(80 + 8 * i));
            end
            begin
                for (int j = 0; j < 4; j++) w_send(bp_data[j], 8'hFF);
            end
        join_none
        repeat (12) @(negedge clk);
        chk("bp_aw_ready", axi_aw_ready, 0);
        chk("bp_w_ready", axi_w_ready, 0);
        chk("bp_aw_count", n_aw_hs - base_aw, 3);
        chk("bp_w_count", n_w_hs - base_w, 3);
        chk("bp_b_valid", axi_b_valid, 1);
        chk("bp_b_id", axi_b_id, 4);
        sync();
        axi_b_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_burst_valid", axi_b_valid, 1);
            chk("bp_burst_id", axi_b_id, 4 + i);
        end
        drain();
        for (int i = 0; i < 4; i++) begin
            read_word(10 + i, v);
            chk("bp_rd", v, bp_data[i]);
        end

        // address wrap and ignored byte offset
        write(4'd9, 32'h0000_081D, 64'hCAFEF00D12345678, 8'hFF);
        drain();
        read_word(3, v);
        chk("wrap_rd", v, 64'hCAFEF00D12345678);

        // reset mid-stream with B pending and FIFOs occupied
        sync();
        axi_b_ready = 1'b0;
        fork
            begin
                aw_send(4'd10, 32'(8 * 20));
                aw_send(4'd11, 32'(8 * 21));
            end
            begin
                w_send(64'h5555, 8'hFF);
                w_send(64'h6666, 8'hFF);
            end
        join
        @(negedge clk);
        chk("pre_rst_b_valid", axi_b_valid, 1);
        sync();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_aw_ready", axi_aw_ready, 0);
        chk("mid_rst_w_ready", axi_w_ready, 0);
        sync();
        @(negedge clk);
        chk("mid_rst_b_valid", axi_b_valid, 0);
        sync();
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_aw_ready", axi_aw_ready, 1);
        chk("after_rst_w_ready", axi_w_ready, 1);
        axi_b_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("no_stale_b", axi_b_valid, 0);
        write(4'd12, 32'(8 * 20), 64'h0123456789ABCDEF, 8'hFF);
        drain();
        read_word(20, v);
        chk("after_rst_rd", v, 64'h0123456789ABCDEF);

        // randomized traffic with random gaps and random B backpressure
        aw_done = 1'b0;
        w_done = 1'b0;
        sync();
        fork
            begin
                for (int i = 0; i < int'(n_rand); i++) begin
                    aw_send(4'($urandom), $urandom);
                    gap($urandom_range(0, 2));
                end
                aw_done = 1'b1;
            end
            begin
                for (int j = 0; j < int'(n_rand); j++) begin
                    w_send({$urandom, $urandom}, 8'($urandom));
                    gap($urandom_range(0, 2));
                end
                w_done = 1'b1;
            end
            begin
                while (!(aw_done && w_done)) begin
                    sync();
                    axi_b_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();
        for (int i = 0; i < 256; i++) begin
            if (kb[i] != 8'h00) begin
                read_word(i, v);
                chk("rand_rd", v & bmask(kb[i]), mem_m[i] & bmask(kb[i]));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
